// File: rtl/l2_bus_scheduler_pkg.sv
// Shared types and constants for the L2 read-port scheduler and its round-robin picker.
// Holds the FSM state encoding, requester ids, the READ opcode and a ceil-log2 helper.
package l2_bus_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } req_id_t;

  localparam logic [1:0] OP_READ = 2'b01;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_rr_pick.sv
// Combinational 2-way round-robin picker: a tie goes to the requester not served last.
// Zero latency; no backpressure, the caller decides when to consume the pick.
module l2_rr_pick
  import l2_bus_scheduler_pkg::*;
(
  input  logic    req1,
  input  logic    req2,
  input  req_id_t last_served,
  output req_id_t winner,
  output logic    any_req
);

  always_comb begin
    any_req = req1 | req2;
    winner  = P1;
    if (req1 && req2) begin
      winner = (last_served == P1) ? P2 : P1;
    end else if (req2) begin
      winner = P2;
    end
  end

endmodule

// File: rtl/l2_bus_scheduler.sv
// Round-robin sequencer for the shared L2 read port: request sampled at edge n -> valid in cycle n+2+L2_LATENCY.
// No backpressure: requesters hold req until their valid pulse; one transaction per L2_LATENCY+3 cycles.
module l2_bus_scheduler
  import l2_bus_scheduler_pkg::*;
#(
  parameter int TAG_WIDTH    = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 2,
  parameter int L2_LATENCY   = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     req1,
  input  logic                                     req2,
  input  logic [TAG_WIDTH-1:0]                     addr1,
  input  logic [TAG_WIDTH-1:0]                     addr2,
  output logic                                     grant1,
  output logic                                     grant2,
  output logic                                     l2_enable,
  output logic [OPCODE_WIDTH+TAG_WIDTH+DATA_WIDTH-1:0] l2_vector_out,
  input  logic [DATA_WIDTH-1:0]                    l2_data_in,
  input  logic                                     l2_hit_in,
  output logic [DATA_WIDTH-1:0]                    data_out1,
  output logic [DATA_WIDTH-1:0]                    data_out2,
  output logic                                     hit_out,
  output logic                                     valid1,
  output logic                                     valid2,
  output logic                                     busy
);

  localparam int CNT_W = log2(L2_LATENCY) + 1;
  localparam int VEC_W = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH;
  localparam logic [VEC_W-1:0] VEC_RESET = {OPCODE_WIDTH'(OP_READ), {(TAG_WIDTH + DATA_WIDTH){1'b0}}};

  state_t               state;
  state_t               state_d;
  req_id_t              last_served;
  req_id_t              winner;
  req_id_t              pick;
  logic                 any_req;
  logic [TAG_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]     cnt;

  l2_rr_pick u_pick (
    .req1        (req1),
    .req2        (req2),
    .last_served (last_served),
    .winner      (pick),
    .any_req     (any_req)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus-facing outputs are registered from the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      winner        <= P1;
      last_served   <= P2;
      addr_q        <= '0;
      cnt           <= '0;
      grant1        <= 1'b0;
      grant2        <= 1'b0;
      l2_enable     <= 1'b0;
      l2_vector_out <= VEC_RESET;
      data_out1     <= '0;
      data_out2     <= '0;
      hit_out       <= 1'b0;
      valid1        <= 1'b0;
      valid2        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      grant1    <= (state inside {ISSUE, WAIT}) && (winner == P1);
      grant2    <= (state inside {ISSUE, WAIT}) && (winner == P2);
      l2_enable <= state inside {ISSUE, WAIT};
      valid1    <= (state == DONE) && (winner == P1);
      valid2    <= (state == DONE) && (winner == P2);
      busy      <= state_d != IDLE;
      case (state)
        IDLE: begin
          if (any_req) begin
            winner <= pick;
            addr_q <= (pick == P1) ? addr1 : addr2;
          end
        end
        ISSUE: begin
          cnt           <= CNT_W'(L2_LATENCY - 1);
          l2_vector_out <= {OPCODE_WIDTH'(OP_READ), addr_q, {DATA_WIDTH{1'b0}}};
        end
        WAIT: begin
          if (cnt == '0) begin
            if (winner == P1) data_out1 <= l2_data_in;
            else              data_out2 <= l2_data_in;
            hit_out <= l2_hit_in;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: last_served <= winner;
        default: ;
      endcase
    end
  end

endmodule
